// File: rtl/ssp_pkg.sv
// Shared types and constants for the SSP transmit path.
package ssp_pkg;

    localparam int FRAME_BITS    = 8;
    // Serial ticks to wait for an unanswered FIFO request before asking again.
    localparam int FETCH_TIMEOUT = 2 * FRAME_BITS;

    typedef enum logic [1:0] {
        IDLE,
        SYNC,
        SHIFT
    } ssp_state_e;

endpackage

// File: rtl/ssp_clk_div.sv
// Serial clock divider: toggles the serial clock every CLK_DIV input clocks and flags
// the cycle in which the serial clock rises.
module ssp_clk_div #(
    parameter int CLK_DIV = 1
) (
    input  logic clk_i,
    input  logic clear_i,
    output logic sclk_o,
    output logic rise_tick_o
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt_q;
    logic          sclk_q;
    logic          term;

    assign term        = (cnt_q == CW'(CLK_DIV - 1));
    assign rise_tick_o = term & ~sclk_q;
    assign sclk_o      = sclk_q;

    always_ff @(posedge clk_i or posedge clear_i) begin
        if (clear_i) begin
            cnt_q  <= '0;
            sclk_q <= 1'b0;
        end else if (term) begin
            cnt_q  <= '0;
            sclk_q <= ~sclk_q;
        end else begin
            cnt_q  <= cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/ssp_tx_logic.sv
// Transmit serializer for the SSP: fetches bytes from the TX FIFO and shifts them out
// MSB-first as TI synchronous-serial frames, chaining frames with no idle gap.
module ssp_tx_logic
    import ssp_pkg::*;
#(
    parameter int CLK_DIV = 1
) (
    input  logic                  PCLK,
    input  logic                  CLEAR,
    input  logic [FRAME_BITS-1:0] TxData,
    input  logic                  tx_ready,
    output logic                  transmit_complete,
    output logic                  SSPCLKOUT,
    output logic                  SSPFSSOUT,
    output logic                  SSPTXD,
    output logic                  SSPOE_B,
    output logic                  tx_busy
);

    localparam int BW  = $clog2(FRAME_BITS);
    localparam int TW  = $clog2(FETCH_TIMEOUT);
    localparam int MSB = FRAME_BITS - 1;

    ssp_state_e            state_q, state_d;
    logic [FRAME_BITS-1:0] hold_q, hold_d;
    logic [FRAME_BITS-1:0] shift_q, shift_d;
    logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [TW-1:0]         to_cnt_q, to_cnt_d;
    logic                  hold_valid_q, hold_valid_d;
    logic                  fetch_pending_q, fetch_pending_d;
    logic                  b2b_q, b2b_d;
    logic                  fss_q, fss_d;
    logic                  txd_q, txd_d;
    logic                  oe_b_q, oe_b_d;
    logic                  tc_q, tc_d;
    logic                  rise_tick;

    ssp_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
        .clk_i       (PCLK),
        .clear_i     (CLEAR),
        .sclk_o      (SSPCLKOUT),
        .rise_tick_o (rise_tick)
    );

    always_comb begin
        state_d         = state_q;
        hold_d          = hold_q;
        shift_d         = shift_q;
        bit_cnt_d       = bit_cnt_q;
        to_cnt_d        = to_cnt_q;
        hold_valid_d    = hold_valid_q;
        fetch_pending_d = fetch_pending_q;
        b2b_d           = b2b_q;
        fss_d           = fss_q;
        txd_d           = txd_q;
        oe_b_d          = oe_b_q;
        tc_d            = 1'b0;

        // A request is only issued with the hold register empty, so a capture
        // (which needs a pending request) never collides with the FSM draining hold.
        if (rise_tick && !hold_valid_q && !fetch_pending_q) begin
            tc_d            = 1'b1;
            fetch_pending_d = 1'b1;
            to_cnt_d        = '0;
        end else if (rise_tick && fetch_pending_q) begin
            if (to_cnt_q == TW'(FETCH_TIMEOUT - 1)) begin
                fetch_pending_d = 1'b0;
                to_cnt_d        = '0;
            end else begin
                to_cnt_d = to_cnt_q + TW'(1);
            end
        end

        if (tx_ready && fetch_pending_q) begin
            hold_d          = TxData;
            hold_valid_d    = 1'b1;
            fetch_pending_d = 1'b0;
        end

        if (rise_tick) begin
            case (state_q)
                IDLE: begin
                    if (hold_valid_q) begin
                        fss_d        = 1'b1;
                        oe_b_d       = 1'b0;
                        shift_d      = hold_q;
                        hold_valid_d = 1'b0;
                        state_d      = SYNC;
                    end
                end
                SYNC: begin
                    fss_d     = 1'b0;
                    txd_d     = shift_q[MSB];
                    shift_d   = shift_q << 1;
                    bit_cnt_d = BW'(FRAME_BITS - 1);
                    state_d   = SHIFT;
                end
                SHIFT: begin
                    if (bit_cnt_q != '0) begin
                        txd_d     = shift_q[MSB];
                        shift_d   = shift_q << 1;
                        bit_cnt_d = bit_cnt_q - BW'(1);
                        // The LSB period doubles as the sync period of a chained frame.
                        if (bit_cnt_q == BW'(1) && hold_valid_q) begin
                            fss_d        = 1'b1;
                            shift_d      = hold_q;
                            hold_valid_d = 1'b0;
                            b2b_d        = 1'b1;
                        end
                    end else if (b2b_q) begin
                        fss_d     = 1'b0;
                        txd_d     = shift_q[MSB];
                        shift_d   = shift_q << 1;
                        bit_cnt_d = BW'(FRAME_BITS - 1);
                        b2b_d     = 1'b0;
                    end else begin
                        txd_d   = 1'b0;
                        oe_b_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge PCLK or posedge CLEAR) begin
        if (CLEAR) begin
            state_q         <= IDLE;
            hold_q          <= '0;
            shift_q         <= '0;
            bit_cnt_q       <= '0;
            to_cnt_q        <= '0;
            hold_valid_q    <= 1'b0;
            fetch_pending_q <= 1'b0;
            b2b_q           <= 1'b0;
            fss_q           <= 1'b0;
            txd_q           <= 1'b0;
            oe_b_q          <= 1'b1;
            tc_q            <= 1'b0;
        end else begin
            state_q         <= state_d;
            hold_q          <= hold_d;
            shift_q         <= shift_d;
            bit_cnt_q       <= bit_cnt_d;
            to_cnt_q        <= to_cnt_d;
            hold_valid_q    <= hold_valid_d;
            fetch_pending_q <= fetch_pending_d;
            b2b_q           <= b2b_d;
            fss_q           <= fss_d;
            txd_q           <= txd_d;
            oe_b_q          <= oe_b_d;
            tc_q            <= tc_d;
        end
    end

    assign transmit_complete = tc_q;
    assign SSPFSSOUT         = fss_q;
    assign SSPTXD            = txd_q;
    assign SSPOE_B           = oe_b_q;
    assign tx_busy           = (state_q != IDLE) | hold_valid_q;

endmodule

// File: tb/tb_ssp_tx_logic.sv
// Bench for ssp_tx_logic: a FIFO responder and a frame decoder on a CLK_DIV=1 instance,
// plus directed checks on a CLK_DIV=3 instance.
`timescale 1ns/1ps
module tb_ssp_tx_logic;

    localparam int FB        = 8;
    // Request tick, then FB*2 unanswered ticks, then a fresh request on the next tick.
    localparam int RETRY_GAP = 2 * (2 * FB + 1);

    logic       PCLK = 1'b0;
    logic       CLEAR = 1'b1;
    logic [7:0] a_data, b_data;
    logic       a_ready, b_ready;
    logic       a_tc, a_sclk, a_fss, a_txd, a_oe_b, a_busy;
    logic       b_tc, b_sclk, b_fss, b_txd, b_oe_b, b_busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int frames_rx = 0;

    byte unsigned fifo_q[$];
    byte unsigned exp_q[$];

    always #5 PCLK = ~PCLK;
    always @(posedge PCLK) cyc <= cyc + 1;

    ssp_tx_logic #(.CLK_DIV(1)) dut_a (
        .PCLK(PCLK), .CLEAR(CLEAR), .TxData(a_data), .tx_ready(a_ready),
        .transmit_complete(a_tc), .SSPCLKOUT(a_sclk), .SSPFSSOUT(a_fss),
        .SSPTXD(a_txd), .SSPOE_B(a_oe_b), .tx_busy(a_busy)
    );

    ssp_tx_logic #(.CLK_DIV(3)) dut_b (
        .PCLK(PCLK), .CLEAR(CLEAR), .TxData(b_data), .tx_ready(b_ready),
        .transmit_complete(b_tc), .SSPCLKOUT(b_sclk), .SSPFSSOUT(b_fss),
        .SSPTXD(b_txd), .SSPOE_B(b_oe_b), .tx_busy(b_busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    function automatic logic sel_sig(input int which);
        case (which)
            0:       return a_tc;
            1:       return a_fss;
            2:       return b_tc;
            default: return b_fss;
        endcase
    endfunction

    task automatic wait_high(input string tag, input int which, input int limit, output int at);
        int n;
        n = 0;
        @(negedge PCLK);
        while (sel_sig(which) !== 1'b1 && n < limit) begin
            @(negedge PCLK);
            n++;
        end
        check(tag, n < limit, 1'b1);
        at = cyc;
    endtask

    task automatic wait_a_idle(input string tag, input int limit);
        int n;
        n = 0;
        @(negedge PCLK);
        while (!(exp_q.size() == 0 && a_oe_b === 1'b1 && a_busy === 1'b0) && n < limit) begin
            @(negedge PCLK);
            n++;
        end
        check(tag, n < limit, 1'b1);
    endtask

    task automatic push_a(input byte unsigned v);
        fifo_q.push_back(v);
        exp_q.push_back(v);
    endtask

    // FIFO model for instance A: answers a request only if it holds data at that moment.
    initial begin
        a_ready = 1'b0;
        a_data  = 8'h00;
        forever begin
            @(negedge PCLK);
            a_ready = 1'b0;
            a_data  = 8'($urandom_range(0, 255));
            if (a_tc === 1'b1 && !CLEAR && fifo_q.size() > 0) begin
                repeat ($urandom_range(0, 2)) @(negedge PCLK);
                a_data  = fifo_q.pop_front();
                a_ready = 1'b1;
            end
        end
    end

    // Frame decoder for instance A: samples data on serial-clock falling edges.
    initial begin
        int bits_left, oe_len, fss_len, frames_in_run;
        logic [7:0] sh;
        logic sclk_prev, fss_prev, oe_prev;
        byte unsigned want;
        bits_left = 0; oe_len = 0; fss_len = 0; frames_in_run = 0;
        sh = 8'h00; sclk_prev = 1'b0; fss_prev = 1'b0; oe_prev = 1'b1;
        forever begin
            @(negedge PCLK);
            if (CLEAR) begin
                bits_left = 0; oe_len = 0; fss_len = 0; frames_in_run = 0;
                sclk_prev = 1'b0; fss_prev = 1'b0; oe_prev = 1'b1;
                continue;
            end
            if (a_fss && !fss_prev) begin
                frames_in_run++;
                check("frame_has_data", exp_q.size() != 0, 1'b1);
            end
            if (a_fss) fss_len++;
            else if (fss_prev) begin
                check("fss_width", fss_len, 2);
                fss_len = 0;
            end
            if (!a_oe_b) oe_len++;
            else if (!oe_prev) begin
                check("oe_window", oe_len, 2 * (1 + 8 * frames_in_run));
                oe_len = 0;
                frames_in_run = 0;
            end
            if (sclk_prev && !a_sclk) begin
                if (!a_oe_b) begin
                    check("in_frame", (bits_left > 0) || a_fss, 1'b1);
                    if (bits_left > 0) begin
                        sh = {sh[6:0], a_txd};
                        bits_left--;
                        if (bits_left == 0) begin
                            want = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
                            frames_rx++;
                            $display("frame %0d: rx=%02h exp=%02h", frames_rx, sh, want);
                            check("rx_byte", sh, want);
                        end
                    end
                    if (a_fss) begin
                        check("fss_align", bits_left, 0);
                        bits_left = 8;
                    end
                end else begin
                    check("idle_lines", {a_fss, a_txd, bits_left != 0}, 3'b000);
                end
            end
            sclk_prev = a_sclk;
            fss_prev  = a_fss;
            oe_prev   = a_oe_b;
        end
    end

    // Instance B: data moves only with a rising serial clock of period 6 PCLK.
    initial begin
        logic sp, tp;
        int last;
        sp = 1'b0; tp = 1'b0; last = -1;
        forever begin
            @(negedge PCLK);
            if (CLEAR) begin
                sp = 1'b0; tp = 1'b0; last = -1;
                continue;
            end
            if (b_txd !== tp) check("b_txd_on_rise", b_sclk && !sp, 1'b1);
            if (b_sclk && !sp) begin
                if (last >= 0) check("b_sclk_period", cyc - last, 6);
                last = cyc;
            end
            sp = b_sclk;
            tp = b_txd;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, t1, n0;
        int n;
        logic a_low_seen, b_low_seen, b_busy_seen;
        logic [7:0] v;
        b_ready = 1'b0;
        b_data  = 8'h00;

        repeat (3) @(posedge PCLK);
        #1;
        check("reset_a", {a_tc, a_sclk, a_fss, a_txd, a_oe_b, a_busy}, 6'b000010);
        check("reset_b", {b_tc, b_sclk, b_fss, b_txd, b_oe_b, b_busy}, 6'b000010);
        @(negedge PCLK);
        CLEAR = 1'b0;

        // Empty FIFO: first request right away, then a retry after the timeout.
        wait_high("tc_first", 0, 10, t0);
        @(negedge PCLK);
        check("tc_pulse_width", a_tc, 1'b0);
        wait_high("tc_retry", 0, 100, t1);
        check("tc_retry_gap", t1 - t0, RETRY_GAP);
        check("empty_idle", {a_oe_b, a_fss, a_busy}, 3'b100);

        push_a(8'hA5);
        wait_a_idle("single_done", 400);
        check("single_busy_end", a_busy, 1'b0);

        push_a(8'h3C);
        push_a(8'hC3);
        wait_a_idle("b2b_done", 400);

        for (int k = 0; k < 25; k++) begin
            n = $urandom_range(1, 3);
            for (int j = 0; j < n; j++) push_a(8'($urandom_range(0, 255)));
            wait_a_idle("burst_done", 600);
            repeat ($urandom_range(0, 40)) @(negedge PCLK);
        end

        // Abort a frame of 0xFF partway through.
        push_a(8'hFF);
        wait_high("abort_start", 1, 200, n0);
        repeat (9) @(negedge PCLK);
        check("abort_mid_frame", {a_oe_b, a_txd}, 2'b01);
        #2 CLEAR = 1'b1;
        #1;
        check("abort_outputs", {a_txd, a_oe_b, a_fss, a_busy, a_tc}, 5'b01000);
        fifo_q.delete();
        exp_q.delete();
        repeat (3) @(negedge PCLK);
        CLEAR = 1'b0;

        // Stray strobe on B before its first request must be ignored.
        b_data  = 8'h5A;
        b_ready = 1'b1;
        repeat (2) @(negedge PCLK);
        b_ready = 1'b0;
        a_low_seen = 1'b0; b_low_seen = 1'b0; b_busy_seen = 1'b0;
        repeat (60) begin
            @(negedge PCLK);
            if (!a_oe_b) a_low_seen = 1'b1;
            if (!b_oe_b) b_low_seen = 1'b1;
            if (b_busy)  b_busy_seen = 1'b1;
        end
        check("a_no_frame_after_clear", a_low_seen, 1'b0);
        check("b_stray_no_frame", {b_low_seen, b_busy_seen}, 2'b00);

        push_a(8'h66);
        wait_a_idle("fresh_fetch_done", 400);

        // CLK_DIV=3 frame of 0x81.
        v = 8'h81;
        wait_high("b_tc", 2, 200, t0);
        b_data  = v;
        b_ready = 1'b1;
        @(negedge PCLK);
        b_ready = 1'b0;
        wait_high("b_fss_start", 3, 20, n0);
        repeat (3) @(negedge PCLK);
        check("b_fss_hold", {b_fss, b_oe_b}, 2'b10);
        for (int i = 0; i < 8; i++) begin
            repeat (6) @(negedge PCLK);
            check("b_bit", {b_oe_b, b_fss, b_txd}, {2'b00, v[7-i]});
        end
        repeat (6) @(negedge PCLK);
        check("b_end", {b_oe_b, b_txd, b_busy}, 3'b100);

        check("exp_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
